buffer_readout: RTL and testbench

BUFFER_READOUT -- requirements
Module: buffer_readout

---
 rtl/buffer_readout.sv | 162 ++++++++++++++++
 tb/tb_buffer_readout.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/buffer_readout.sv
// Streams a 21-bit capture buffer out as 3 bytes per word over a valid/ready link.
// The first byte of each word carries bit 7 set so the host can realign frames.
module buffer_readout #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 21,
  parameter int LAST_ADDR = 2047
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] addr_r,
  input  logic [DATA_W-1:0] data_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int LANES  = 3;
  localparam int LANE_W = 7;
  localparam logic [ADDR_W-1:0] LAST_ADDR_V = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] word_reg;
  logic [1:0]        index_reg;
  logic [7:0]        tx_data_reg;
  logic              tx_valid_reg;
  logic              overrun_reg;

  logic              xfer;
  logic              at_last;
  logic [DATA_W-1:0] src_word;
  logic [7:0]        lane_byte [LANES];
  logic [7:0]        next_byte;

  assign xfer    = tx_valid_reg && tx_ready;
  assign at_last = (addr_reg == LAST_ADDR_V);

  // In LOAD the word register is not yet valid, so the first byte comes straight from the buffer.
  assign src_word = (state_reg == LOAD) ? data_out : word_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_byte[gi] = {(gi == 0) ? 1'b1 : 1'b0,
                              src_word[DATA_W-1-gi*LANE_W -: LANE_W]};
    end
  endgenerate

  always_comb begin
    next_byte = lane_byte[0];
    if (state_reg == SEND) begin
      case (index_reg)
        2'd0:    next_byte = lane_byte[1];
        default: next_byte = lane_byte[2];
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = SEND;
      end
      SEND: begin
        if (xfer && (index_reg == 2'd2)) begin
          state_next = at_last ? DONE : LOAD;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      word_reg     <= '0;
      index_reg    <= 2'd0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg    <= '0;
            overrun_reg <= 1'b0;
          end
        end
        LOAD: begin
          word_reg     <= data_out;
          tx_data_reg  <= next_byte;
          tx_valid_reg <= 1'b1;
          index_reg    <= 2'd0;
        end
        SEND: begin
          // Without a transfer nothing changes, which holds tx_data/tx_valid under backpressure.
          if (xfer) begin
            if (index_reg == 2'd2) begin
              tx_valid_reg <= 1'b0;
              if (!at_last) begin
                addr_reg <= addr_reg + ADDR_W'(1);
              end
            end else begin
              tx_data_reg <= next_byte;
              index_reg   <= index_reg + 2'd1;
            end
          end
        end
        default: begin
        end
      endcase
      if (start && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign addr_r   = addr_reg;
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_buffer_readout.sv
// Directed bench for buffer_readout: reset, full readout, byte packing,
// backpressure, overrun and mid-readout reset.
module tb_buffer_readout;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 21;
  localparam int LAST_ADDR = 2047;
  localparam int NWORDS    = LAST_ADDR + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              overrun;

  logic [DATA_W-1:0] mem [NWORDS];
  logic [7:0]        got [3];
  int                pass_cnt = 0;
  int                total_cnt = 0;
  int                xfer_cnt = 0;
  int                base_cnt;

  buffer_readout #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LAST_ADDR(LAST_ADDR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .addr_r  (addr_r),
    .data_out(data_out),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  assign data_out = mem[addr_r];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      xfer_cnt <= xfer_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [20:0] w, input int b);
    case (b)
      0:       return {1'b1, w[20:14]};
      1:       return {1'b0, w[13:7]};
      default: return {1'b0, w[6:0]};
    endcase
  endfunction

  // Entered with the DUT in LOAD for word w; leaves it in LOAD of w+1 (or DONE).
  task automatic run_word(input int w, input int stall);
    tx_ready = 1'($urandom);
    chk($sformatf("load_flags_w%0d", w), 32'({busy, done, tx_valid}), 32'(3'b100));
    chk($sformatf("load_addr_w%0d", w), 32'(addr_r), 32'(w));
    tick();
    start    = 1'b0;
    tx_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("byte_w%0d_b%0d", w, b), 32'({tx_valid, tx_data}),
          32'({1'b1, exp_byte(mem[w], b)}));
      got[b] = tx_data;
      if (b == 1 && stall > 0) begin
        tx_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick();
          chk($sformatf("bp_hold_c%0d", s), 32'({tx_valid, tx_data}),
              32'({1'b1, exp_byte(mem[w], 1)}));
        end
        tx_ready = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = DATA_W'(i);
    end

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      start    = 1'($urandom);
      tx_ready = 1'($urandom);
      tick();
      chk("reset_outs", 32'({addr_r, tx_data, tx_valid, busy, done, overrun}), 32'd0);
    end
    rst_n    = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b0;
    tick();
    chk("post_reset_outs", 32'({addr_r, tx_data, tx_valid, busy, done, overrun}), 32'd0);
    $display("reset: outputs checked while held and after release");

    // Readout A: mem[i]=i, no stalls
    base_cnt = xfer_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < NWORDS; w++) begin
      run_word(w, 0);
      if (w == 0) begin
        chk("first_byte", 32'(got[0]), 32'h80);
      end
    end
    chk("last_word_bytes", 32'({got[0], got[1], got[2]}), 32'h800F7F);
    chk("done_pulse", 32'({busy, done}), 32'(2'b11));
    chk("bytes_a", 32'(xfer_cnt - base_cnt), 32'd6144);
    tick();
    chk("after_done", 32'({busy, done, tx_valid, overrun}), 32'd0);
    $display("readout A: %0d bytes transferred", xfer_cnt - base_cnt);

    // Readout B: packing patterns, backpressure on word 2, overrun at word 100
    mem[0] = 21'h1FFFFF;
    mem[1] = 21'h155555;
    base_cnt = xfer_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < NWORDS; w++) begin
      if (w == 100) begin
        start = 1'b1;
      end
      run_word(w, (w == 2) ? 10 : 0);
      if (w == 0) begin
        chk("pack_1fffff", 32'({got[0], got[1], got[2]}), 32'hFF7F7F);
      end
      if (w == 1) begin
        chk("pack_155555", 32'({got[0], got[1], got[2]}), 32'hD52A55);
      end
      if (w == 100) begin
        chk("overrun_set", 32'({overrun, busy}), 32'(2'b11));
      end
    end
    chk("done_pulse_b", 32'({busy, done}), 32'(2'b11));
    chk("bytes_b", 32'(xfer_cnt - base_cnt), 32'd6144);
    tick();
    chk("overrun_sticky", 32'({busy, done, overrun}), 32'(3'b001));
    $display("readout B: %0d bytes, overrun=%0b", xfer_cnt - base_cnt, overrun);

    // Readout C: accepted start clears overrun; reset during word 500
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("overrun_cleared", 32'({overrun, busy}), 32'(2'b01));
    for (int w = 0; w < 500; w++) begin
      run_word(w, 0);
    end
    chk("w500_load_addr", 32'(addr_r), 32'd500);
    tick();
    tx_ready = 1'b1;
    chk("w500_byte0", 32'({tx_valid, tx_data}), 32'({1'b1, exp_byte(mem[500], 0)}));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({tx_valid, busy, done, overrun, addr_r, tx_data}), 32'd0);
    base_cnt = xfer_cnt;
    tick();
    tick();
    chk("no_bytes_in_reset", 32'(xfer_cnt - base_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'({busy, tx_valid, addr_r}), 32'd0);
    $display("readout C: aborted by reset during word 500");

    // Readout D: restart from address 0
    start = 1'b1;
    tick();
    start = 1'b0;
    run_word(0, 0);
    chk("restart_first_byte", 32'(got[0]), 32'hFF);
    run_word(1, 0);
    $display("readout D: restarted at address 0");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
